// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_op/req_a/req_b  : packed per-requester opcode and operands
//   rsp_valid/rsp_ready : one-hot response handshake (bit i = requester i)
//   rsp_res/rsp_zero    : registered ALU result and ZERO flag
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int unsigned W   = 8,
  parameter int unsigned OPW = 5
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*OPW-1:0] req_op;
  logic [2*W-1:0]   req_a;
  logic [2*W-1:0]   req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [W-1:0]     rsp_res;
  logic             rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and the
// address/PC-update unit (requester 1). Round-robin grant, one op in flight,
// operands held stable for MOD_LAT cycles on MOD, result registered on return.
// Ports:
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   bus (slave)           : request/response handshakes, see alu_share_arbiter_if
//   alu_op/inOne/inTwo    : drive the shared ALU, zero outside EXEC
//   alu_res/alu_zero      : shared ALU outputs
//   grant_cnt0/grant_cnt1 : saturating accept counters, only with ALU_ARB_STATS_EN
// Optional feature macro: ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned W       = 8,
  parameter int unsigned OPW     = 5,
  parameter int unsigned MOD_LAT = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  alu_share_arbiter_if.slave  bus,
  output logic [OPW-1:0]      alu_op,
  output logic [W-1:0]        alu_inOne,
  output logic [W-1:0]        alu_inTwo,
  input  logic [W-1:0]        alu_res,
  input  logic                alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned STAT_W = 16;
  localparam logic [OPW-1:0] OP_MOD = OPW'(5'b01111);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [OPW-1:0]   op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic [W-1:0]     res_q;
  logic             zero_q;
  logic [1:0]       rsp_valid_q;

  logic             winner_c;
  logic             accept_c;
  logic [1:0]       ready_c;
  logic [OPW-1:0]   sel_op_c;
  logic [W-1:0]     sel_a_c;
  logic [W-1:0]     sel_b_c;

  // Winner: sole valid requester, or the one not granted last on a tie.
  always_comb begin
    winner_c = 1'b0;
    if (&bus.req_valid) begin
      winner_c = ~last_q;
    end else begin
      winner_c = bus.req_valid[1];
    end
  end

  // Accept in IDLE whenever anyone is valid; ready goes only to the winner.
  // Gated by RESET_N so ready reads 0 while reset is asserted.
  always_comb begin
    accept_c = (state_q == IDLE) && (|bus.req_valid) && RESET_N;
    ready_c  = 2'b00;
    if (accept_c) begin
      ready_c = winner_c ? 2'b10 : 2'b01;
    end
  end

  // Mux the winning requester's payload.
  always_comb begin
    sel_op_c = bus.req_op[OPW*32'(winner_c) +: OPW];
    sel_a_c  = bus.req_a[W*32'(winner_c) +: W];
    sel_b_c  = bus.req_b[W*32'(winner_c) +: W];
  end

  // Control FSM and datapath registers. op_q/a_q/b_q double as the ALU drive
  // and are cleared on leaving EXEC so the ALU sees 0 outside EXEC.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      res_q       <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            op_q    <= sel_op_c;
            a_q     <= sel_a_c;
            b_q     <= sel_b_c;
            owner_q <= winner_c;
            last_q  <= winner_c;
            cnt_q   <= (sel_op_c == OP_MOD) ? CNT_W'(MOD_LAT - 1) : '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_q       <= alu_res;
            zero_q      <= alu_zero;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] gcnt0_q;
  logic [STAT_W-1:0] gcnt1_q;

  // Per-requester accept counters, saturating at all-ones.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else if (accept_c) begin
      if (!winner_c && (gcnt0_q != '1)) begin
        gcnt0_q <= gcnt0_q + STAT_W'(1);
      end
      if (winner_c && (gcnt1_q != '1)) begin
        gcnt1_q <= gcnt1_q + STAT_W'(1);
      end
    end
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`endif

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_zero  = zero_q;
  assign alu_op        = op_q;
  assign alu_inOne     = a_q;
  assign alu_inTwo     = b_q;

endmodule
